// File: rtl/tx_control.sv
// tx_control: frames buffered result words into SYNC/LEN/payload[/CHK] packets for async_transmitter.
// Optional TX_CHECKSUM_EN adds the CHK state and XOR accumulator; default build omits them.
//
//   state | meaning
//   IDLE  | waiting for send; busy drops here one cycle after the final byte pulse
//   HDR   | issue SYNC_BYTE
//   LEN   | issue latched word count
//   DATA  | issue payload bytes, LSB first, popping each word on its last byte
//   CHK   | issue XOR checksum (TX_CHECKSUM_EN only)
module tx_control #(
  parameter int WORD_BYTES = 2,
  parameter int DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wen,
  input  logic [8*WORD_BYTES-1:0]   inWord,
  input  logic                      send,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      busy,
  output logic                      TxD_start,
  output logic [7:0]                TxD_data,
  input  logic                      TxD_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    DATA
`ifdef TX_CHECKSUM_EN
    , CHK
`endif
  } stateT;

  stateT state;

  logic [8*WORD_BYTES-1:0] mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW:0]   countNext;
  logic [7:0]    lenReg;
  logic [7:0]    wordsLeft;
  logic [IW-1:0] byteIdx;
  logic          guard;
  logic          issue;
  logic          pop;
  logic          push;
  logic [7:0]    dataByte;
  logic [7:0]    nextByte;
`ifdef TX_CHECKSUM_EN
  logic [7:0]    chkAcc;
`endif

  // guard covers the transmitter's one-cycle lag before TxD_busy rises
  assign issue    = (state != IDLE) && !guard && !TxD_busy;
  assign pop      = issue && (state == DATA) && (byteIdx == LAST_IDX);
  assign push     = wen && (!full || pop);
  assign dataByte = 8'(mem[rdPtr] >> (8 * byteIdx));

  always_comb begin
    nextByte = 8'h00;
    case (state)
      HDR:  nextByte = SYNC_BYTE;
      LEN:  nextByte = lenReg;
      DATA: nextByte = dataByte;
`ifdef TX_CHECKSUM_EN
      CHK:  nextByte = chkAcc;
`endif
      default: nextByte = 8'h00;
    endcase
  end

  always_comb begin
    countNext = count;
    if (push && !pop)
      countNext = count + (PW+1)'(1);
    else if (pop && !push)
      countNext = count - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= inWord;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + PW'(1);
      if (pop)
        rdPtr <= rdPtr + PW'(1);
      count <= countNext;
      full  <= (countNext == (PW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      TxD_start <= 1'b0;
      TxD_data  <= 8'h00;
      guard     <= 1'b0;
      lenReg    <= 8'h00;
      wordsLeft <= 8'h00;
      byteIdx   <= '0;
`ifdef TX_CHECKSUM_EN
      chkAcc    <= 8'h00;
`endif
    end else begin
      TxD_start <= issue;
      guard     <= issue;
      if (issue)
        TxD_data <= nextByte;
`ifdef TX_CHECKSUM_EN
      if (issue && (state == LEN || state == DATA))
        chkAcc <= chkAcc ^ nextByte;
`endif
      case (state)
        IDLE: begin
          if (send) begin
            state     <= HDR;
            busy      <= 1'b1;
            lenReg    <= 8'(count);
            wordsLeft <= 8'(count);
            byteIdx   <= '0;
`ifdef TX_CHECKSUM_EN
            chkAcc    <= 8'h00;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        HDR: begin
          if (issue)
            state <= LEN;
        end
        LEN: begin
          if (issue) begin
            if (lenReg != 8'h00)
              state <= DATA;
            else
`ifdef TX_CHECKSUM_EN
              state <= CHK;
`else
              state <= IDLE;
`endif
          end
        end
        DATA: begin
          if (issue) begin
            if (byteIdx == LAST_IDX) begin
              byteIdx   <= '0;
              wordsLeft <= wordsLeft - 8'd1;
              if (wordsLeft == 8'd1)
`ifdef TX_CHECKSUM_EN
                state <= CHK;
`else
                state <= IDLE;
`endif
            end else begin
              byteIdx <= byteIdx + IW'(1);
            end
          end
        end
`ifdef TX_CHECKSUM_EN
        CHK: begin
          if (issue)
            state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_control.sv
// Directed bench for tx_control: checks packet bytes on the line, handshake timing and FIFO status.
// Expected CHK bytes are appended only when TX_CHECKSUM_EN is defined.
module tb_tx_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [15:0] inWord;
  logic        send;
  logic [4:0]  count;
  logic        full;
  logic        busy;
  logic        TxD_start;
  logic [7:0]  TxD_data;
  logic        TxD_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];
  int   busyCnt = 0;
  logic stallHold = 1'b0;
  int   startsSeen;

  tx_control dut (
    .clk(clk), .reset(reset), .wen(wen), .inWord(inWord), .send(send),
    .count(count), .full(full), .busy(busy),
    .TxD_start(TxD_start), .TxD_data(TxD_data), .TxD_busy(TxD_busy)
  );

  always #5 clk = ~clk;

  // transmitter model: busy for three cycles per byte, optionally held busy
  assign TxD_busy = stallHold || (busyCnt != 0);

  always @(negedge clk) begin
    if (TxD_start) begin
      rxQ.push_back(TxD_data);
      busyCnt = 3;
    end else if (busyCnt > 0) begin
      busyCnt = busyCnt - 1;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [15:0] w);
    wen = 1'b1;
    inWord = w;
    tick();
    wen = 1'b0;
  endtask

  task automatic pulseSend();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    checkVal({tag, "_idle"}, busy, 0);
  endtask

  task automatic checkPacket(input string tag);
    checkVal({tag, "_nbytes"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      if (i < rxQ.size())
        checkVal($sformatf("%s_b%0d", tag, i), rxQ[i], expQ[i]);
    rxQ.delete();
    expQ.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; wen = 1'b0; send = 1'b0; inWord = 16'h0;
    repeat (3) tick();
    checkVal("rst_count", count, 0);
    checkVal("rst_full", full, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_start", TxD_start, 0);
    checkVal("rst_data", TxD_data, 8'h00);
    reset = 1'b0;
    tick();

    // basic packet with start latency
    writeWord(16'h1234);
    writeWord(16'hABCD);
    checkVal("basic_count", count, 2);
    checkVal("basic_full", full, 0);
    pulseSend();
    checkVal("lat_busy", busy, 1);
    checkVal("lat_nostart", TxD_start, 0);
    tick();
    checkVal("lat_start", TxD_start, 1);
    checkVal("lat_sync", TxD_data, 8'hA5);
    waitIdle("basic");
    expQ = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
`ifdef TX_CHECKSUM_EN
    expQ.push_back(8'h42);
`endif
    checkPacket("basic");
    checkVal("basic_count_end", count, 0);

    // empty packet
    pulseSend();
    waitIdle("empty");
    expQ = '{8'hA5, 8'h00};
`ifdef TX_CHECKSUM_EN
    expQ.push_back(8'h00);
`endif
    checkPacket("empty");

    // overflow: 17th word dropped
    for (int i = 0; i < 17; i++)
      writeWord(16'(i));
    checkVal("ovf_count", count, 16);
    checkVal("ovf_full", full, 1);
    pulseSend();
    waitIdle("ovf");
    expQ = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(8'(i));
      expQ.push_back(8'h00);
    end
`ifdef TX_CHECKSUM_EN
    expQ.push_back(8'h10);
`endif
    checkPacket("ovf");
    checkVal("ovf_count_end", count, 0);
    checkVal("ovf_full_end", full, 0);

    // stall after SYNC
    writeWord(16'h5A3C);
    pulseSend();
    n = 0;
    while (!TxD_start && n < 50) begin
      tick();
      n++;
    end
    checkVal("stall_sync_seen", TxD_start, 1);
    stallHold = 1'b1;
    startsSeen = 0;
    repeat (100) begin
      tick();
      if (TxD_start) startsSeen++;
    end
    checkVal("stall_quiet", startsSeen, 0);
    stallHold = 1'b0;
    tick();
    checkVal("stall_len_start", TxD_start, 1);
    checkVal("stall_len_data", TxD_data, 8'h01);
    waitIdle("stall");
    expQ = '{8'hA5, 8'h01, 8'h3C, 8'h5A};
`ifdef TX_CHECKSUM_EN
    expQ.push_back(8'h67);
`endif
    checkPacket("stall");

    // concurrent write during a packet
    writeWord(16'h1111);
    writeWord(16'h2222);
    writeWord(16'h3333);
    pulseSend();
    repeat (3) tick();
    writeWord(16'h4444);
    writeWord(16'h5555);
    waitIdle("conc1");
    expQ = '{8'hA5, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
`ifdef TX_CHECKSUM_EN
    expQ.push_back(8'h03);
`endif
    checkPacket("conc1");
    checkVal("conc_count_mid", count, 2);
    pulseSend();
    waitIdle("conc2");
    expQ = '{8'hA5, 8'h02, 8'h44, 8'h44, 8'h55, 8'h55};
`ifdef TX_CHECKSUM_EN
    expQ.push_back(8'h02);
`endif
    checkPacket("conc2");
    checkVal("conc_count_end", count, 0);

    // reset during DATA
    writeWord(16'h0102);
    writeWord(16'h0304);
    pulseSend();
    n = 0;
    while (rxQ.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    checkVal("rstmid_in_data", rxQ.size(), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("rstmid_busy", busy, 0);
    checkVal("rstmid_count", count, 0);
    checkVal("rstmid_start", TxD_start, 0);
    checkVal("rstmid_full", full, 0);
    repeat (6) tick();
    rxQ.delete();
    writeWord(16'hBEEF);
    pulseSend();
    waitIdle("rstmid");
    expQ = '{8'hA5, 8'h01, 8'hEF, 8'hBE};
`ifdef TX_CHECKSUM_EN
    expQ.push_back(8'h50);
`endif
    checkPacket("rstmid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
